// File: rtl/turf_buffer_manager.sv
// Allocates TURF digitization buffers A-D to triggers and drives digitize requests to the event generator.
// Held buffers wait in a completion-order readout queue until the host releases them; deadtime and drops are counted.
module turf_buffer_manager #(
    parameter int DIGITIZE_WIDTH = 2,
    parameter int TIMEOUT        = 1023
) (
    input  logic        clk33_i,
    input  logic        rst_i,
    input  logic        clr_all_i,
    input  logic        trig_i,
    input  logic [3:0]  trig_source_i,
    output logic        digitize_o,
    output logic [1:0]  digitize_buffer_o,
    output logic [3:0]  digitize_source_o,
    output logic [3:0]  buffer_status_o,
    input  logic        event_done_i,
    input  logic [1:0]  event_buffer_i,
    output logic        ready_o,
    output logic [1:0]  ready_buffer_o,
    input  logic        release_i,
    output logic        busy_o,
    output logic [15:0] dead_count_o,
    output logic [15:0] drop_count_o,
    output logic        error_o
);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_WAIT_DONE} state_t;
    typedef enum logic [1:0] {B_FREE, B_DIG, B_HELD} buf_t;

    localparam logic [3:0] WIDTH_LAST = 4'(DIGITIZE_WIDTH - 1);
    localparam logic [9:0] TO_LAST    = 10'(TIMEOUT - 1);

    state_t      state_q, state_d;
    buf_t        buf_q [4];
    buf_t        buf_d [4];
    logic [1:0]  next_ptr_q, next_ptr_d;
    logic [1:0]  dig_idx_q, dig_idx_d;
    logic [3:0]  dig_src_q, dig_src_d;
    logic [3:0]  status_q, status_d;
    logic [3:0]  width_q, width_d;
    logic [9:0]  to_q, to_d;
    logic [1:0]  mem_q [4];
    logic [1:0]  rd_ptr_q, wr_ptr_q;
    logic [2:0]  occ_q;
    logic [15:0] dead_q, drop_q;
    logic        error_q;

    logic        free_any;
    logic [3:0]  held_mask;
    logic [1:0]  alloc_idx;
    logic        alloc_found;
    logic [1:0]  cand;
    logic        push, pop, err_set;

    always_comb begin
        free_any  = 1'b0;
        held_mask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (buf_q[i] == B_FREE) free_any = 1'b1;
            held_mask[i] = (buf_q[i] == B_HELD);
        end
    end

    // Round-robin search starting at next_ptr so buffers are used in rotation.
    always_comb begin
        alloc_idx   = next_ptr_q;
        alloc_found = 1'b0;
        cand        = next_ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = next_ptr_q + 2'(k);
            if (!alloc_found && buf_q[cand] == B_FREE) begin
                alloc_idx   = cand;
                alloc_found = 1'b1;
            end
        end
    end

    assign busy_o = (state_q != S_IDLE) || !free_any;
    assign pop    = release_i && (occ_q != 3'd0);

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        next_ptr_d = next_ptr_q;
        dig_idx_d  = dig_idx_q;
        dig_src_d  = dig_src_q;
        status_d   = status_q;
        width_d    = width_q;
        to_d       = to_q;
        push       = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig_i && free_any) begin
                    state_d          = S_ASSERT;
                    buf_d[alloc_idx] = B_DIG;
                    next_ptr_d       = alloc_idx + 2'd1;
                    dig_idx_d        = alloc_idx;
                    dig_src_d        = trig_source_i;
                    status_d         = held_mask;
                    width_d          = 4'd0;
                end
            end
            S_ASSERT: begin
                if (width_q == WIDTH_LAST) begin
                    state_d = S_WAIT_DONE;
                    to_d    = 10'd0;
                end else begin
                    width_d = width_q + 4'd1;
                end
            end
            S_WAIT_DONE: begin
                if (event_done_i) begin
                    state_d          = S_IDLE;
                    buf_d[dig_idx_q] = B_HELD;
                    push             = 1'b1;
                    err_set          = (event_buffer_i != dig_idx_q);
                end else if (to_q == TO_LAST) begin
                    state_d          = S_IDLE;
                    buf_d[dig_idx_q] = B_FREE;
                    err_set          = 1'b1;
                end else begin
                    to_d = to_q + 10'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The popped buffer is HELD, so it never collides with the DIG buffer updated above.
        if (pop) buf_d[mem_q[rd_ptr_q]] = B_FREE;
    end

    always_ff @(posedge clk33_i) begin
        if (rst_i || clr_all_i) begin
            state_q    <= S_IDLE;
            next_ptr_q <= 2'd0;
            width_q    <= 4'd0;
            to_q       <= 10'd0;
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
            occ_q      <= 3'd0;
            dead_q     <= 16'd0;
            drop_q     <= 16'd0;
            error_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= B_FREE;
                mem_q[i] <= 2'd0;
            end
        end else begin
            state_q    <= state_d;
            next_ptr_q <= next_ptr_d;
            width_q    <= width_d;
            to_q       <= to_d;
            for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
            if (push) begin
                mem_q[wr_ptr_q] <= dig_idx_q;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            if (push && !pop)      occ_q <= occ_q + 3'd1;
            else if (pop && !push) occ_q <= occ_q - 3'd1;
            if (busy_o && dead_q != 16'hFFFF)           dead_q <= dead_q + 16'd1;
            if (trig_i && busy_o && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            error_q <= error_q | err_set;
        end
    end

    // Trigger capture survives a flush; it only changes on the next acceptance.
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            dig_idx_q <= 2'd0;
            dig_src_q <= 4'd0;
            status_q  <= 4'd0;
        end else begin
            dig_idx_q <= dig_idx_d;
            dig_src_q <= dig_src_d;
            status_q  <= status_d;
        end
    end

    assign digitize_o        = (state_q == S_ASSERT);
    assign digitize_buffer_o = dig_idx_q;
    assign digitize_source_o = dig_src_q;
    assign buffer_status_o   = status_q;
    assign ready_o           = (occ_q != 3'd0);
    assign ready_buffer_o    = mem_q[rd_ptr_q];
    assign dead_count_o      = dead_q;
    assign drop_count_o      = drop_q;
    assign error_o           = error_q;

endmodule

// File: doc/turf_buffer_manager.md
# turf_buffer_manager

Allocates the four TURF digitization buffers (A–D) to incoming triggers and issues the digitize request to the event generator. Tracks each buffer as free, digitizing or held, and keeps held buffers in a completion-order readout queue that the host side releases. Also accumulates deadtime and dropped-trigger counts. Sits between the trigger logic and the event generator, all in the 33 MHz domain.

## Interface
- DIGITIZE_WIDTH, 2: cycles `digitize_o` is held high; legal range 1–15.
- TIMEOUT, 1023: maximum cycles spent in WAIT_DONE before abort; 10-bit counter.
- clk33_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- clr_all_i  in  1  synchronous flush; priority below `rst_i`, above everything else.
- trig_i  in  1  single-cycle trigger request.
- trig_source_i  in  4  trigger source, captured with the trigger.
- digitize_o  out  1  digitize request to the event generator.
- digitize_buffer_o  out  2  allocated buffer index.
- digitize_source_o  out  4  captured source.
- buffer_status_o  out  4  mask of held buffers, captured at allocation.
- event_done_i  in  1  event-complete pulse from the event generator.
- event_buffer_i  in  2  buffer index reported with `event_done_i`.
- ready_o  out  1  readout queue not empty.
- ready_buffer_o  out  2  buffer index at the head of the queue.
- release_i  in  1  host frees the head-of-queue buffer.
- busy_o  out  1  trigger cannot be accepted this cycle.
- dead_count_o  out  16  cycles with `busy_o` high; saturates at 0xFFFF.
- drop_count_o  out  16  number of dropped triggers; saturates at 0xFFFF.
- error_o  out  1  sticky error flag.

## Operation
- Per-buffer state is FREE, DIG or HELD.
- `free_any` = at least one buffer is FREE.
- `busy_o` = (state != IDLE) || !`free_any`.

State machine:
- IDLE: `trig_i` && `free_any` → ASSERT. On entry to ASSERT:
  - choose the first FREE buffer at or after `next_ptr`, searching modulo 4;
  - mark the chosen buffer DIG;
  - set `next_ptr` to chosen+1, wrapping 3→0;
  - latch the chosen index, `trig_source_i`, and the HELD mask taken before allocation.
- ASSERT: `digitize_o` high; after DIGITIZE_WIDTH cycles → WAIT_DONE.
- WAIT_DONE: `event_done_i` → IDLE.
  - The DIG buffer becomes HELD and its index is pushed to the queue.
  - If `event_buffer_i` ≠ the DIG index, set `error_o`; the DIG index is still the one queued.
- WAIT_DONE timeout: TIMEOUT cycles without `event_done_i` → IDLE. The DIG buffer returns to FREE, is not queued, and `error_o` is set.

Trigger and done handling:
- A `trig_i` seen while `busy_o` is high is dropped and increments `drop_count_o`.
- `event_done_i` outside WAIT_DONE is ignored and has no error effect.

Readout queue:
- 4-deep FIFO of 2-bit indices with a 3-bit occupancy. It cannot overflow, since at most 4 buffers exist.
- `release_i` with occupancy > 0: pop the head, mark that buffer FREE.
- `release_i` with an empty queue: ignored.

Simultaneous events:
- Push and pop in the same cycle: pop acts on the registered head; occupancy is unchanged.
- If the queue was empty, the release is ignored and the push still occurs.
- A release that frees a buffer in cycle N makes `free_any` true from N+1.

`clr_all_i`:
- FSM → IDLE, all buffers FREE, queue emptied, `next_ptr` = 0.
- Both counters cleared, `error_o` cleared.
- `digitize_o` drops the following cycle, even mid-ASSERT.

## Timing
- Reset values (all outputs):
  - `digitize_o`, `ready_o`, `busy_o`, `error_o` = 0;
  - `digitize_buffer_o`, `buffer_status_o`, `ready_buffer_o`, `digitize_source_o` = 0;
  - both counters = 0; FSM IDLE; `next_ptr` 0.
- `trig_i` accepted in cycle N:
  - `digitize_o` = 1 in cycles N+1 … N+DIGITIZE_WIDTH;
  - `digitize_buffer_o`, `digitize_source_o` and `buffer_status_o` valid from N+1 and stable until the next acceptance;
  - `busy_o` = 1 from N+1.
- `event_done_i` in cycle M (WAIT_DONE):
  - IDLE, and the buffer is HELD, at M+1;
  - `ready_o` and `ready_buffer_o` update at M+1;
  - the earliest next trigger acceptance is M+1.
- `release_i` in cycle R: `ready_o` and `ready_buffer_o` reflect the new head at R+1.
- Counters register one cycle after their cause.
- Timeout: abort in the cycle the WAIT_DONE counter reaches TIMEOUT; IDLE on the next cycle.

## Test plan
- Reset, then `trig_i` with source 0x5 → `digitize_o` high for 2 cycles starting the next cycle, buffer 0, status 0000. Then `event_done_i` with buffer 0 → `ready_o` = 1 with `ready_buffer_o` = 0; the next trigger takes buffer 1.
- Four triggers, each completed, with no release → buffers 0,1,2,3 queued in order; `buffer_status_o` 0000,0001,0011,0111. The fifth trigger is dropped: `drop_count_o` = 1 and `dead_count_o` increments every cycle.
- Same four held, `release_i` once → buffer 0 freed; `ready_buffer_o` = 1; the next trigger is allocated buffer 0, via wrap of `next_ptr`.
- `trig_i` during ASSERT/WAIT_DONE → dropped, `drop_count_o` increments. Counter forced past 0xFFFF → holds at 0xFFFF.
- `event_done_i` with mismatching index → `error_o` = 1 and the DIG index is queued. No done for 1023 cycles → buffer returns FREE, `error_o` = 1, FSM IDLE.
- `clr_all_i` mid-ASSERT with 2 held buffers → `digitize_o` = 0 the next cycle, `ready_o` = 0, counters and `error_o` = 0, and the next trigger is allocated buffer 0.
